// File: rtl/centroid_update_ctrl.sv
// Centroid-update sequencer: serial divide of accumulated sums by member count, clamp, write back.
// Optional round-to-nearest dividend when CENTROID_ROUND_EN is defined.

module centroid_update_ctrl #(
   parameter int unsigned centroid_num     = 8,
   parameter int unsigned accum_cord_width = 22,
   parameter int unsigned cordinate_width  = 13,
   parameter int unsigned count_width      = 10,
   parameter int unsigned addrWidth        = 8,
   parameter int unsigned dataWidth        = 91,
   localparam int unsigned N_COORD         = dataWidth / cordinate_width
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic [addrWidth-1:0]                  acc_sel,
   input  logic [N_COORD*accum_cord_width-1:0]   acc_sums,
   input  logic [count_width-1:0]                acc_count,
   output logic                                  div_start,
   output logic [accum_cord_width-1:0]           div_dividend,
   output logic [count_width-1:0]                div_divisor,
   input  logic [accum_cord_width-1:0]           div_quotient,
   input  logic                                  div_done,
   output logic [N_COORD*accum_cord_width-1:0]   result_cords,
   output logic                                  mem_wr_en,
   output logic [addrWidth-1:0]                  mem_wr_addr,
   output logic                                  ovf_flag
);

   localparam int unsigned ACW  = accum_cord_width;
   localparam int unsigned ACW1 = ACW + 1;
   localparam int unsigned C_W  = $clog2(N_COORD);
   localparam logic [C_W-1:0]       C_LAST    = C_W'(N_COORD - 1);
   localparam logic [addrWidth-1:0] K_LAST    = addrWidth'(centroid_num - 1);
   localparam logic [ACW-1:0]       CLAMP_MAX = ACW'((64'd1 << cordinate_width) - 64'd1);

   typedef enum logic [2:0] {
      IDLE, LOAD, DIV_REQ, DIV_WAIT, WRITE, NEXT
   } state_t;

   state_t                       state_q, state_d;
   logic [addrWidth-1:0]         k_q, k_d;
   logic [C_W-1:0]               c_q, c_d, c_inc;
   logic [N_COORD*ACW-1:0]       sums_q, sums_d;
   logic [count_width-1:0]       count_q, count_d;

   logic                         busy_d, done_d, div_start_d, mem_wr_en_d, ovf_d;
   logic [addrWidth-1:0]         acc_sel_d, mem_wr_addr_d;
   logic [ACW-1:0]               div_dividend_d;
   logic [count_width-1:0]       div_divisor_d;
   logic [N_COORD*ACW-1:0]       result_d;

   logic [ACW-1:0]               sum_src, dividend_calc, q_clamped;
   logic [count_width-1:0]       div_src;
   logic                         q_ovf;
`ifdef CENTROID_ROUND_EN
   logic [ACW1-1:0]              rounded;
`endif

   // Operand for the next division: live bank data in LOAD, captured copy afterwards
   always_comb begin
      c_inc = (c_q == C_LAST) ? c_q : c_q + C_W'(1);
      if (state_q == LOAD) begin
         sum_src = acc_sums[ACW-1:0];
         div_src = acc_count;
      end else begin
         sum_src = sums_q[32'(c_inc) * ACW +: ACW];
         div_src = count_q;
      end
`ifdef CENTROID_ROUND_EN
      rounded       = {1'b0, sum_src} + ACW1'(div_src >> 1);
      dividend_calc = rounded[ACW] ? '1 : rounded[ACW-1:0];
`else
      dividend_calc = sum_src;
`endif
   end

   // Saturate the quotient to coordinate width
   always_comb begin
      q_ovf     = (div_quotient > CLAMP_MAX);
      q_clamped = q_ovf ? CLAMP_MAX : div_quotient;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      c_d            = c_q;
      sums_d         = sums_q;
      count_d        = count_q;
      busy_d         = busy;
      done_d         = 1'b0;
      div_start_d    = 1'b0;
      mem_wr_en_d    = 1'b0;
      acc_sel_d      = acc_sel;
      mem_wr_addr_d  = mem_wr_addr;
      div_dividend_d = div_dividend;
      div_divisor_d  = div_divisor;
      result_d       = result_cords;
      ovf_d          = ovf_flag;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               k_d       = '0;
               c_d       = '0;
               acc_sel_d = '0;
               busy_d    = 1'b1;
               ovf_d     = 1'b0;
            end
         end
         LOAD: begin
            sums_d  = acc_sums;
            count_d = acc_count;
            c_d     = '0;
            if (acc_count == '0) begin
               state_d = NEXT;
            end else begin
               state_d        = DIV_REQ;
               div_start_d    = 1'b1;
               div_dividend_d = dividend_calc;
               div_divisor_d  = div_src;
            end
         end
         DIV_REQ: begin
            state_d = DIV_WAIT;
         end
         DIV_WAIT: begin
            if (div_done) begin
               result_d[32'(c_q) * ACW +: ACW] = q_clamped;
               if (q_ovf) ovf_d = 1'b1;
               if (c_q == C_LAST) begin
                  state_d       = WRITE;
                  mem_wr_en_d   = 1'b1;
                  mem_wr_addr_d = k_q;
               end else begin
                  state_d        = DIV_REQ;
                  c_d            = c_inc;
                  div_start_d    = 1'b1;
                  div_dividend_d = dividend_calc;
                  div_divisor_d  = div_src;
               end
            end
         end
         WRITE: begin
            state_d = NEXT;
         end
         NEXT: begin
            if (k_q == K_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d   = LOAD;
               k_d       = k_q + addrWidth'(1);
               acc_sel_d = k_q + addrWidth'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         k_q          <= '0;
         c_q          <= '0;
         sums_q       <= '0;
         count_q      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         div_start    <= 1'b0;
         mem_wr_en    <= 1'b0;
         acc_sel      <= '0;
         mem_wr_addr  <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
         result_cords <= '0;
         ovf_flag     <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         c_q          <= c_d;
         sums_q       <= sums_d;
         count_q      <= count_d;
         busy         <= busy_d;
         done         <= done_d;
         div_start    <= div_start_d;
         mem_wr_en    <= mem_wr_en_d;
         acc_sel      <= acc_sel_d;
         mem_wr_addr  <= mem_wr_addr_d;
         div_dividend <= div_dividend_d;
         div_divisor  <= div_divisor_d;
         result_cords <= result_d;
         ovf_flag     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_centroid_update_ctrl.sv
// Self-checking bench for centroid_update_ctrl: behavioural divider/accumulator bank and
// an arithmetic reference of each update pass (honours CENTROID_ROUND_EN).

module tb_centroid_update_ctrl;

   logic         clk, rst_n, start;
   logic         busy, done, div_start, div_done, mem_wr_en, ovf_flag;
   logic [7:0]   acc_sel, mem_wr_addr;
   logic [153:0] acc_sums, result_cords;
   logic [9:0]   acc_count, div_divisor;
   logic [21:0]  div_dividend, div_quotient;

   centroid_update_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .acc_sel(acc_sel), .acc_sums(acc_sums), .acc_count(acc_count),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_done(div_done), .result_cords(result_cords),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .ovf_flag(ovf_flag)
   );

   typedef struct {
      logic [7:0]   addr;
      logic [153:0] data;
   } wr_t;

   logic [21:0] sums [8][7];
   logic [9:0]  counts [8];
   wr_t         wr_q[$];
   wr_t         exp_q[$];
   bit          exp_ovf;
   int          exp_cycles;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat = 3;
   bit          spur_en = 0;
   bit          dv_pend = 0;
   int          dv_cnt;
   logic [21:0] dv_q;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Accumulator bank: combinational read by acc_sel
   always_comb begin
      acc_sums  = '0;
      acc_count = '0;
      if (acc_sel < 8'd8) begin
         for (int i = 0; i < 7; i++) acc_sums[i*22 +: 22] = sums[acc_sel[2:0]][i];
         acc_count = counts[acc_sel[2:0]];
      end
   end

   // Serial divider with latency lat; optional spurious done pulses while not dividing
   initial begin
      div_done     = 1'b0;
      div_quotient = '0;
      forever begin
         @(posedge clk);
         #1;
         div_done     = 1'b0;
         div_quotient = 22'($urandom);
         if (rst_n !== 1'b1) begin
            dv_pend = 0;
         end else if (dv_pend) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
               div_done     = 1'b1;
               div_quotient = dv_q;
               dv_pend      = 0;
            end
         end else if (div_start === 1'b1) begin
            dv_q    = (div_divisor == '0) ? '1 : div_dividend / 22'(div_divisor);
            dv_cnt  = lat;
            dv_pend = 1;
         end else if (spur_en && busy === 1'b1 && $urandom_range(0, 2) == 0) begin
            div_done = 1'b1;
         end
      end
   end

   // Memory write monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mem_wr_en === 1'b1) wr_q.push_back('{mem_wr_addr, result_cords});
      end
   end

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each nonzero centroid written with per-coordinate clamped quotient
   task automatic build_expect(input int d);
      longint dvd, q;
      logic [153:0] w;
      exp_q.delete();
      exp_ovf    = 0;
      exp_cycles = 0;
      for (int k = 0; k < 8; k++) begin
         if (counts[k] == 0) begin
            exp_cycles += 2;
         end else begin
            exp_cycles += 3 + 7 * (1 + d);
            w = '0;
            for (int i = 0; i < 7; i++) begin
               dvd = longint'(sums[k][i]);
`ifdef CENTROID_ROUND_EN
               dvd = dvd + longint'(counts[k]) / 2;
               if (dvd > 4194303) dvd = 4194303;
`endif
               q = dvd / longint'(counts[k]);
               if (q > 8191) begin
                  q       = 8191;
                  exp_ovf = 1;
               end
               w[i*22 +: 22] = 22'(q);
            end
            exp_q.push_back('{8'(k), w});
         end
      end
   endtask

   task automatic fill_random(input bit allow_zero);
      for (int k = 0; k < 8; k++) begin
         counts[k] = (allow_zero && $urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
         for (int i = 0; i < 7; i++) sums[k][i] = 22'($urandom) >> $urandom_range(0, 21);
      end
   endtask

   task automatic run_pass(input string name, input int d, input bit noise, output int cycles);
      int guard;
      build_expect(d);
      lat     = d;
      spur_en = noise;
      wr_q.delete();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({name, ":busy_rise"}, 160'(busy), 160'(1));
      check({name, ":ovf_clr"}, 160'(ovf_flag), 160'(0));
      check({name, ":acc_sel0"}, 160'(acc_sel), 160'(0));
      cycles = 0;
      guard  = 0;
      while (busy === 1'b1 && guard < 20000) begin
         cycles++;
         start = noise && ($urandom_range(0, 7) == 0);
         @(posedge clk);
         #1;
         guard++;
      end
      start = 1'b0;
      spur_en = 0;
      check({name, ":no_timeout"}, 160'(guard < 20000), 160'(1));
      check({name, ":cycles"}, 160'(cycles), 160'(exp_cycles));
      check({name, ":done"}, 160'(done), 160'(1));
      check({name, ":wr_count"}, 160'(wr_q.size()), 160'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < wr_q.size(); j++) begin
         check({name, ":wr_addr"}, 160'(wr_q[j].addr), 160'(exp_q[j].addr));
         check({name, ":wr_data"}, 160'(wr_q[j].data), 160'(exp_q[j].data));
      end
      check({name, ":ovf"}, 160'(ovf_flag), 160'(exp_ovf));
      @(posedge clk);
      #1;
      check({name, ":done_pulse"}, 160'(done), 160'(0));
   endtask

   task automatic check_reset_values(input string name);
      check({name, ":busy"}, 160'(busy), 160'(0));
      check({name, ":done"}, 160'(done), 160'(0));
      check({name, ":div_start"}, 160'(div_start), 160'(0));
      check({name, ":mem_wr_en"}, 160'(mem_wr_en), 160'(0));
      check({name, ":acc_sel"}, 160'(acc_sel), 160'(0));
      check({name, ":mem_wr_addr"}, 160'(mem_wr_addr), 160'(0));
      check({name, ":div_dividend"}, 160'(div_dividend), 160'(0));
      check({name, ":div_divisor"}, 160'(div_divisor), 160'(0));
      check({name, ":result_cords"}, 160'(result_cords), 160'(0));
      check({name, ":ovf_flag"}, 160'(ovf_flag), 160'(0));
   endtask

   initial begin
      int cyc;
      int n;
      bit found;
      rst_n = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         counts[k] = '0;
         for (int i = 0; i < 7; i++) sums[k][i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 check_reset_values("reset");
      @(negedge clk) rst_n = 1'b1;

      // Uniform data: every coordinate 400/4 = 100, 248 busy cycles at D=3
      for (int k = 0; k < 8; k++) begin
         counts[k] = 10'd4;
         for (int i = 0; i < 7; i++) sums[k][i] = 22'd400;
      end
      run_pass("uniform", 3, 0, cyc);
      check("uniform:cycles_248", 160'(cyc), 160'(248));
      if (wr_q.size() == 8) check("uniform:slot", 160'(wr_q[7].data[6*22 +: 22]), 160'(100));

      // Empty centroid 2 is skipped; spurious done pulses and start while busy are ignored
      fill_random(0);
      for (int k = 0; k < 8; k++) counts[k] = 10'd1;
      counts[2] = 10'd0;
      run_pass("zero_cnt", 2, 1, cyc);
      n = 0;
      foreach (wr_q[j]) if (wr_q[j].addr == 8'd2) n++;
      check("zero_cnt:no_addr2", 160'(n), 160'(0));

      // Clamp of 2^21 to 8191; ovf_flag sticky until the next start
      fill_random(1);
      sums[0][0] = 22'h200000;
      counts[0]  = 10'd1;
      run_pass("clamp", 1, 0, cyc);
      if (wr_q.size() > 0) check("clamp:slot", 160'(wr_q[0].data[21:0]), 160'(8191));
      repeat (5) @(posedge clk);
      #1 check("clamp:ovf_sticky", 160'(ovf_flag), 160'(1));

      // 7/2: truncation gives 3, rounding gives 4
      fill_random(1);
      sums[0][0] = 22'd7;
      counts[0]  = 10'd2;
      run_pass("round", 5, 0, cyc);
`ifdef CENTROID_ROUND_EN
      if (wr_q.size() > 0) check("round:slot", 160'(wr_q[0].data[21:0]), 160'(4));
`else
      if (wr_q.size() > 0) check("round:slot", 160'(wr_q[0].data[21:0]), 160'(3));
`endif

      // Randomized passes
      for (int p = 0; p < 3; p++) begin
         fill_random(1);
         run_pass("random", $urandom_range(1, 6), 1'($urandom_range(0, 1)), cyc);
      end

      // Reset in DIV_WAIT of centroid 5
      fill_random(0);
      lat = 4;
      wr_q.delete();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 0;
      for (int t = 0; t < 2000 && !found; t++) begin
         @(negedge clk);
         if (acc_sel == 8'd5 && dv_pend && div_start === 1'b0) found = 1;
      end
      check("midreset:reached", 160'(found), 160'(1));
      rst_n = 1'b0;
      #1 check_reset_values("midreset");
      repeat (3) @(posedge clk);
      #1 check("midreset:hold", 160'(mem_wr_en), 160'(0));
      n = 0;
      foreach (wr_q[j]) if (wr_q[j].addr == 8'd5) n++;
      check("midreset:no_addr5", 160'(n), 160'(0));
      check("midreset:partial_writes", 160'(wr_q.size()), 160'(5));
      @(negedge clk) rst_n = 1'b1;
      fill_random(1);
      run_pass("after_reset", 3, 0, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/centroid_update_ctrl.md
# centroid_update_ctrl

Sequencer for the centroid-update phase of the k-means engine. After an accumulation pass it walks every centroid, divides each of its 7 accumulated coordinate sums by the centroid's member count through one shared serial divider, clamps each quotient to coordinate width, and drives the write of the new 91-bit centroid into centroid memory via the fixed-point concatenation stage. Centroids with zero members keep their old value (no write).

## Interface
- centroid_num, 8, number of centroids walked per pass
- accum_cord_width, 22, width of one accumulated coordinate sum and of the divider quotient
- cordinate_width, 13, width of one stored centroid coordinate
- count_width, 10, width of member count / divisor
- addrWidth, 8, centroid memory address width
- dataWidth, 91, centroid word width (7*cordinate_width)

- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begin an update pass (ignored while busy)
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse when the pass completes
- acc_sel  output  addrWidth  centroid index being read from accumulator bank
- acc_sums  input  7*accum_cord_width  7 coordinate sums for acc_sel, coord 1 in LSBs; combinational, valid same cycle
- acc_count  input  count_width  member count for acc_sel, same timing
- div_start  output  1  one-cycle pulse launching a division
- div_dividend  output  accum_cord_width  held stable from div_start until div_done
- div_divisor  output  count_width  held stable likewise
- div_quotient  input  accum_cord_width  valid when div_done=1
- div_done  input  1  one-cycle pulse from divider
- result_cords  output  7*accum_cord_width  clamped quotients, coord 1 in LSBs; feeds result_cord_1..7 of concatenator
- mem_wr_en  output  1  one-cycle write strobe to centroid memory
- mem_wr_addr  output  addrWidth  write address (= centroid index)
- ovf_flag  output  1  sticky: some quotient clamped this pass

## Operation
- FSM: IDLE, LOAD, DIV_REQ, DIV_WAIT, WRITE, NEXT.
- IDLE: on start -> LOAD with k=0, ovf_flag cleared.
- LOAD: acc_sel=k; register acc_sums and acc_count. If count==0 -> NEXT (no divides, no write); else c=0 -> DIV_REQ.
- DIV_REQ: div_start=1 for one cycle with dividend=sum[c], divisor=count -> DIV_WAIT.
- DIV_WAIT: on div_done capture quotient into result_cords slot c; c<6 -> c+1, DIV_REQ; c==6 -> WRITE.
- WRITE: mem_wr_en=1, mem_wr_addr=k for one cycle -> NEXT.
- NEXT: k==centroid_num-1 -> IDLE with done=1; else k+1 -> LOAD.
- Arithmetic unsigned. Quotient > 2^cordinate_width-1 stored as 2^cordinate_width-1 (8191) in low bits, upper bits of slot zero; sets ovf_flag. Otherwise stored zero-extended.
- result_cords holds last written centroid until next capture.
- div_done outside DIV_WAIT ignored. start while busy ignored.

## Timing
- Reset: busy=0, done=0, div_start=0, mem_wr_en=0, acc_sel=0, mem_wr_addr=0, div_dividend=0, div_divisor=0, result_cords=0, ovf_flag=0; FSM IDLE, k=c=0.
- start sampled in IDLE; busy rises next cycle.
- Divider latency D cycles (div_start to div_done, D>=1, any value).
- Per nonzero centroid: 1 (LOAD) + 7*(1+D) + 1 (WRITE) + 1 (NEXT) cycles. Zero-count centroid: 2 cycles.
- mem_wr_en asserted in the cycle after the 7th capture; result_cords already final in that cycle.
- done coincides with busy falling; new start accepted the cycle after done.
- rst_n low mid-pass: immediate return to reset values; no partial write completes.

## Configuration
- CENTROID_ROUND_EN defined: dividend = sum[c] + (count>>1) (round to nearest), sum widened by one bit internally before clamp; if sum+count/2 exceeds 2^accum_cord_width-1, dividend saturates to all ones.
- Undefined: dividend = sum[c] (truncating division).

## Test plan
- Single pass, all counts=4, all sums=400, divider D=3 -> 8 writes addr 0..7, each slot=100, done after 8*(1+7*4+2)=248 cycles, ovf_flag=0.
- Centroid 2 count=0, others count=1 -> no write to addr 2, 7 writes, centroid 2 takes 2 cycles.
- Sum=2^21, count=1 -> slot clamped to 8191, ovf_flag=1 held to next start.
- Sum=7, count=2 -> 3 without CENTROID_ROUND_EN, 4 with it.
- start pulsed while busy and spurious div_done in LOAD -> ignored, results unchanged.
- rst_n low during DIV_WAIT of centroid 5 -> all outputs reset values, no write to addr 5; new start runs a clean full pass.
